// File: rtl/dump_hex_formatter.sv
// dump_hex_formatter: pulls captured words from the bus snooper one at a time and
// streams each as uppercase ASCII hex followed by CR LF over a valid/ready byte port.
module dump_hex_formatter #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 128
) (
  input  logic                comm_clock,
  input  logic                reset_n,
  input  logic                start,
  output logic                word_req,
  input  logic                word_valid,
  input  logic [BITWIDTH-1:0] word_data,
  input  logic                word_last,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done
);
  localparam int DIGITS = BITWIDTH / 4;
  localparam int CW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH - 1);
  localparam logic [DW-1:0] DIGIT_MAX = DW'(DIGITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DIGIT  = 3'd3;
  localparam logic [2:0] S_CR     = 3'd4;
  localparam logic [2:0] S_LF     = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  logic [2:0]          state_r;
  logic [CW-1:0]       word_count_r;
  logic [DW-1:0]       digit_r;
  logic [BITWIDTH-1:0] shift_r;
  logic                last_r;
  logic                word_req_r;
  logic [7:0]          tx_data_r;
  logic                tx_valid_r;
  logic                busy_r;
  logic                done_r;
  logic                xfer_s;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      hex_ascii = 8'h30 + {4'h0, nib};
    end else begin
      hex_ascii = 8'h37 + {4'h0, nib};
    end
  endfunction

  assign xfer_s   = tx_valid_r && tx_ready;
  assign word_req = word_req_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Dump sequencer; every output is registered so tx_data/tx_valid only move on a transfer.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      word_count_r <= '0;
      digit_r      <= '0;
      shift_r      <= '0;
      last_r       <= 1'b0;
      word_req_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      tx_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            busy_r       <= 1'b1;
            word_count_r <= '0;
            word_req_r   <= 1'b1;
            state_r      <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          word_req_r <= 1'b0;
          // The shift register holds the nibbles still to be sent, the leading one goes out now.
          if (word_valid) begin
            shift_r    <= word_data << 4;
            last_r     <= word_last || (word_count_r == COUNT_MAX);
            digit_r    <= DIGIT_MAX;
            tx_data_r  <= hex_ascii(word_data[BITWIDTH-1 -: 4]);
            tx_valid_r <= 1'b1;
            state_r    <= S_DIGIT;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_DIGIT: begin
          if (xfer_s) begin
            if (digit_r == '0) begin
              tx_data_r <= 8'h0D;
              state_r   <= S_CR;
            end else begin
              tx_data_r <= hex_ascii(shift_r[BITWIDTH-1 -: 4]);
              shift_r   <= shift_r << 4;
              digit_r   <= digit_r - DW'(1);
            end
          end
        end
        S_CR: begin
          if (xfer_s) begin
            tx_data_r <= 8'h0A;
            state_r   <= S_LF;
          end
        end
        S_LF: begin
          if (xfer_s) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            if (last_r) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= S_FINISH;
            end else begin
              word_count_r <= word_count_r + CW'(1);
              word_req_r   <= 1'b1;
              state_r      <= S_REQ;
            end
          end
        end
        S_FINISH: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          word_req_r <= 1'b0;
          tx_valid_r <= 1'b0;
          tx_data_r  <= 8'h00;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end
endmodule
